sel_arbiter_8: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8-bit-addressed, 256-line one-hot select resource between NREQ requesters.
- Accepts one address per grant and drives the one-hot select line for exactly HOLD_CYC cycles.
- Sits between independent bus masters and the 256-entry select fabric; the fabric sees at most one active line at any time.

---
 rtl/sel_pkg.sv | 17 +
 rtl/sel_onehot_dec.sv | 26 ++
 rtl/sel_arbiter_8.sv | 104 ++++++++++
 tb/tb_sel_arbiter_8.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sel_pkg.sv
// Shared constants, state encoding and index helper for the 256-line select arbiter.
package sel_pkg;

  localparam int unsigned SEL_ADDR_W = 8;
  localparam int unsigned SEL_LINES  = 256;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } sel_state_e;

  // Requester index reached by stepping 'off' places from 'base', wrapping modulo n.
  function automatic int unsigned wrap_idx(int unsigned base, int unsigned off, int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/sel_onehot_dec.sv
// 8-bit address to 256-line one-hot decode, built from two 4-to-16 nibble decodes.
module sel_onehot_dec
  import sel_pkg::*;
(
  input  logic [SEL_ADDR_W-1:0] addr,
  input  logic                  en,
  output logic [SEL_LINES-1:0]  onehot
);

  logic [15:0] hi_dec;
  logic [15:0] lo_dec;

  always_comb begin
    hi_dec = '0;
    lo_dec = '0;
    hi_dec[addr[7:4]] = 1'b1;
    lo_dec[addr[3:0]] = en;
  end

  for (genvar h = 0; h < 16; h++) begin : g_hi
    for (genvar l = 0; l < 16; l++) begin : g_lo
      assign onehot[16*h+l] = hi_dec[h] & lo_dec[l];
    end
  end

endmodule

// File: rtl/sel_arbiter_8.sv
// Round-robin arbiter sharing one 256-line one-hot select resource among NREQ requesters;
// each grant holds its select line for HOLD_CYC cycles.
module sel_arbiter_8
  import sel_pkg::*;
#(
  parameter int unsigned  NREQ     = 4,
  parameter int unsigned  HOLD_CYC = 2,
  localparam int unsigned OWN_W    = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*SEL_ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]              req_ready,
  output logic                         sel_valid,
  output logic [SEL_ADDR_W-1:0]        sel_addr,
  output logic [SEL_LINES-1:0]         sel_onehot,
  output logic [OWN_W-1:0]             sel_owner,
  output logic                         busy
);

  localparam int unsigned        CNT_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(HOLD_CYC - 1);

  sel_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OWN_W-1:0]       ptr_q, ptr_d;
  logic [OWN_W-1:0]       owner_q, owner_d;
  logic [SEL_ADDR_W-1:0]  addr_q, addr_d;
  logic [OWN_W-1:0]       winner;
  logic                   found;
  logic                   window;

  // Counter sits at zero in idle, so the window test covers both states.
  assign window = (state_q == StIdle) || (cnt_q == '0);

  // First valid requester scanning upward from the pointer with wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req_valid[OWN_W'(wrap_idx(32'(ptr_q), k, NREQ))]) begin
        found  = 1'b1;
        winner = OWN_W'(wrap_idx(32'(ptr_q), k, NREQ));
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && window && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    if (window) begin
      if (found) begin
        state_d = StActive;
        cnt_d   = CNT_LOAD;
        ptr_d   = OWN_W'(wrap_idx(32'(winner), 1, NREQ));
        owner_d = winner;
        addr_d  = req_addr[32'(winner)*SEL_ADDR_W +: SEL_ADDR_W];
      end else begin
        state_d = StIdle;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
    end
  end

  assign sel_valid = (state_q == StActive);
  assign busy      = sel_valid;
  assign sel_addr  = addr_q;
  assign sel_owner = owner_q;

  sel_onehot_dec u_dec (
    .addr   (addr_q),
    .en     (sel_valid),
    .onehot (sel_onehot)
  );

endmodule

// File: tb/tb_sel_arbiter_8.sv
// Scoreboard bench: two arbiters (HOLD_CYC 2 and 1) share stimulus and are checked
// against a cycle-stamped reference model of the grant rules.
module tb_sel_arbiter_8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;

  logic [3:0]   rdy [2];
  logic         sv  [2];
  logic [7:0]   sa  [2];
  logic [255:0] oh  [2];
  logic [1:0]   so  [2];
  logic         bz  [2];

  sel_arbiter_8 #(.NREQ(4), .HOLD_CYC(2)) u_h2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy[0]), .sel_valid(sv[0]), .sel_addr(sa[0]), .sel_onehot(oh[0]),
    .sel_owner(so[0]), .busy(bz[0])
  );

  sel_arbiter_8 #(.NREQ(4), .HOLD_CYC(1)) u_h1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy[1]), .sel_valid(sv[1]), .sel_addr(sa[1]), .sel_onehot(oh[1]),
    .sel_owner(so[1]), .busy(bz[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int inst;
    int cyc;
    int owner;
    int addr;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   ptr [2];
  int   busy_end [2];

  function automatic int hold_of(int j);
    return (j == 0) ? 2 : 1;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a window is open once the previous grant's last hold cycle is reached.
  always @(negedge clk) begin
    if (rst) begin
      ptr[0] = 0; ptr[1] = 0;
      busy_end[0] = 0; busy_end[1] = 0;
      sbq.delete();
    end else begin
      for (int j = 0; j < 2; j++) begin
        int win;
        int i;
        logic [3:0] er;
        win = -1;
        er  = '0;
        if (cyc >= busy_end[j]) begin
          for (int k = 0; k < 4; k++) begin
            i = (ptr[j] + k) % 4;
            if (win < 0 && req_valid[i]) win = i;
          end
        end
        if (win >= 0) er[win] = 1'b1;
        chk($sformatf("ready_h%0d", hold_of(j)), 256'(rdy[j]), 256'(er));
        if (win >= 0) begin
          for (int h = 1; h <= hold_of(j); h++)
            sbq.push_back('{j, cyc + h, win, int'(req_addr[8*win +: 8])});
          ptr[j] = (win + 1) % 4;
          busy_end[j] = cyc + hold_of(j);
        end
      end
    end
  end

  // Monitor: pops the oldest expectation of each instance when its cycle comes due.
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 2; j++) begin
        int idx;
        logic exp_v;
        logic [255:0] eoh;
        exp_t e;
        idx = -1;
        for (int k = 0; k < sbq.size(); k++)
          if (idx < 0 && sbq[k].inst == j) idx = k;
        exp_v = (idx >= 0) && (sbq[idx].cyc == cyc);
        chk($sformatf("sel_valid_h%0d", hold_of(j)), 256'(sv[j]), 256'(exp_v));
        chk($sformatf("busy_h%0d", hold_of(j)), 256'(bz[j]), 256'(exp_v));
        eoh = '0;
        if (exp_v) begin
          e = sbq[idx];
          sbq.delete(idx);
          eoh[e.addr] = 1'b1;
          chk($sformatf("sel_addr_h%0d", hold_of(j)), 256'(sa[j]), 256'(e.addr));
          chk($sformatf("sel_owner_h%0d", hold_of(j)), 256'(so[j]), 256'(e.owner));
        end
        chk($sformatf("sel_onehot_h%0d", hold_of(j)), oh[j], eoh);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_addr  = 32'h0;
    repeat (2) tick();
    for (int j = 0; j < 2; j++) begin
      chk("reset_sel_valid", 256'(sv[j]), 256'(0));
      chk("reset_sel_addr", 256'(sa[j]), 256'(0));
      chk("reset_sel_owner", 256'(so[j]), 256'(0));
      chk("reset_onehot", oh[j], 256'(0));
      chk("reset_ready", 256'(rdy[j]), 256'(0));
    end
    req_valid = 4'h0;
    rst = 1'b0;
    tick();

    // Single grant of requester 2 at 0xC3.
    req_valid = 4'b0100;
    req_addr  = 32'h00C3_0000;
    #1 chk("single_ready", 256'(rdy[0]), 256'(4'b0100));
    tick();
    req_valid = 4'h0;
    chk("single_bit195", 256'(oh[0][195]), 256'(1));
    chk("single_owner", 256'(so[0]), 256'(2));
    repeat (3) tick();

    // Pointer now 3: lone requester 1 wins, then 3 beats 1.
    req_valid = 4'b0010;
    req_addr  = 32'h4400_1100;
    tick();
    req_valid = 4'h0;
    repeat (2) tick();
    req_valid = 4'b1010;
    #1 chk("wrap_3_beats_1", 256'(rdy[0]), 256'(4'b1000));
    tick();
    req_valid = 4'h0;
    repeat (3) tick();

    // Reset in the middle of a hold.
    req_valid = 4'b0010;
    req_addr  = 32'h0000_5A00;
    tick();
    chk("pre_reset_active", 256'(sv[0]), 256'(1));
    rst = 1'b1;
    #1;
    chk("async_sel_valid", 256'(sv[0]), 256'(0));
    chk("async_onehot", oh[0], 256'(0));
    chk("async_ready_h2", 256'(rdy[0]), 256'(0));
    chk("async_ready_h1", 256'(rdy[1]), 256'(0));
    repeat (2) tick();
    rst = 1'b0;
    req_valid = 4'h0;
    repeat (3) tick();

    // Round-robin with all four requesting.
    req_valid = 4'hF;
    req_addr  = 32'h3322_1100;
    repeat (10) tick();
    req_valid = 4'h0;
    repeat (3) tick();

    // Requester 0 alone with incrementing addresses across the 0xFF wrap.
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0001;
      req_addr  = {24'h0, 8'(8'hFE + i)};
      tick();
    end
    req_valid = 4'h0;
    repeat (4) tick();

    // Request withdrawn while the hold counter is nonzero.
    req_valid = 4'b0001;
    req_addr  = 32'h0000_2277;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'h0;
    repeat (4) tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_addr  = $urandom;
      tick();
    end
    req_valid = 4'h0;
    repeat (5) tick();
    chk("scoreboard_drained", 256'(sbq.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
